weight_rom_stream_ctrl: RTL
===========================

// Module: weight_rom_stream_ctrl
// PURPOSE
//  Sequences a pipelined weight ROM (fixed read latency, ce-gated) and turns it into a
//  flow-controlled valid/ready stream. Generates addresses, counts passes over the tensor
//  and tracks in-flight reads. A small output FIFO absorbs ROM data, so downstream back-pressure
//  never drops or duplicates a word. Sits between a weight ROM and the consuming linear/matmul stage.
// PARAMETERS
//  DATA_WIDTH   128               ROM word width (bits)
//  DEPTH        576               words per tensor pass (>=1)
//  ADDR_WIDTH   $clog2(DEPTH)+1   ROM address width
//  ROM_LATENCY  2                 cycles from address sampled to rom_q valid (1..4)
//  PASS_WIDTH   16                width of pass counter
//  FIFO_DEPTH   ROM_LATENCY+2     output FIFO entries (localparam, not overridable)
// PORTS
//  clk             in   1            clock, rising edge
//  rst             in   1            asynchronous reset, active-high
//  start           in   1            begin job; sampled only in IDLE
//  num_passes      in   PASS_WIDTH   passes over addresses 0..DEPTH-1; sampled with start
//  abort           in   1            synchronous flush; return to IDLE, no done
//  busy            out  1            high in RUN or DRAIN
//  done            out  1            one-cycle pulse at job completion
//  rom_addr        out  ADDR_WIDTH   ROM address (registered)
//  rom_ce          out  1            ROM clock enable; high whenever state != IDLE
//  rom_q           in   DATA_WIDTH   ROM read data
//  data_out        out  DATA_WIDTH   FIFO head word
//  data_out_valid  out  1            FIFO non-empty
//  data_out_ready  in   1            consumer accepts; pop = valid & ready
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0, rom_ce=0, busy=0, done=0, data_out_valid=0, data_out=0;
//   FIFO, in-flight shift register and counters cleared.
//  FSM:
//   IDLE->RUN    start && num_passes!=0; latch num_passes; addr=0; pass=0.
//   IDLE->IDLE   start && num_passes==0; done pulses next cycle.
//   RUN->DRAIN   same cycle the last address (DEPTH-1) of the last pass is issued.
//   DRAIN->IDLE  inflight==0 && FIFO empty; done pulses for 1 cycle on entry to IDLE.
//   any->IDLE    abort (RUN/DRAIN): clear FIFO and in-flight tags; no done; abort beats rst? no, rst dominates.
//  Issue rule (RUN): issue iff inflight + fifo_count < FIFO_DEPTH. On issue, the rom_addr
//   register takes the next address and a valid tag enters a ROM_LATENCY-deep shift register.
//   The rule does not look at data_out_ready, so there is no combinational path ready->addr.
//  Data path: the tag exiting the shift register writes rom_q into the FIFO that cycle.
//   Sizing guarantees the FIFO never overflows (overflow = assertion failure). Simultaneous
//   push+pop keeps the count.
//  Latency: start in cycle 0 -> first address issued in cycle 1 -> data_out_valid in cycle
//   ROM_LATENCY+2 (=4 at default).
//  Throughput: 1 word/cycle sustained while ready stays high.
//  Wrap: after addr DEPTH-1, addr->0 and pass++. DEPTH==1 issues addr 0 on every pass.
//  Ordering: words leave in issue order (addr 0..DEPTH-1, repeated per pass); exactly
//   DEPTH*num_passes words per job.
//  start while busy: ignored. rst mid-job: immediate async return to reset values.
//  data_out is stable while valid && !ready.
// TESTING
//  1 DEPTH=4, passes=1, ready=1: start -> words a0..a3 on cycles 4..7, done in cycle 8, busy low after.
//  2 DEPTH=576, passes=3, ready=1: 1728 words in order, no gaps after the first, exactly one done.
//  3 DEPTH=8, passes=2, ready held low 10 cycles mid-stream: valid held, data stable,
//    no loss or duplication; fifo_count <= 4 at all times.
//  4 random ready (50%) across 5 passes, DEPTH=7: output sequence == (0..6) x5; scoreboard clean.
//  5 start with num_passes=0 -> done pulse next cycle, rom_ce stays 0, no data_out_valid.
//  6 abort at word 5 of 16, then async rst pulse mid-job: no done after either; all outputs
//    reach reset values; a new start replays from addr 0.

Source files
------------

// File: rtl/weight_rom_stream_ctrl.sv
// weight_rom_stream_ctrl
// Walks a pipelined, ce-gated weight ROM over addresses 0..DEPTH-1 for a
// requested number of passes. The ROM output is turned into a valid/ready
// stream through a small FIFO. Reads are only issued when the FIFO is
// guaranteed to have room for them, so back-pressure never drops a word.
module weight_rom_stream_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 576,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int FIFO_DEPTH = ROM_LATENCY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = CNT_W + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [PASS_WIDTH-1:0]   r_pass;
    logic [PASS_WIDTH-1:0]   r_numPasses;
    logic [ROM_LATENCY-1:0]  r_tags;
    logic [ROM_LATENCY-1:0]  w_tagsNext;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_countNext;
    logic [CNT_W-1:0]        w_inflight;
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic                    r_done;
    logic                    w_doneNext;
    logic                    w_issue;
    logic                    w_lastIssue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_launch;
    logic                    w_drained;

    assign busy           = (r_state != S_IDLE);
    assign rom_ce         = (r_state != S_IDLE);
    assign rom_addr       = r_addr;
    assign done           = r_done;
    assign data_out_valid = (r_count != '0);
    assign data_out       = (r_count != '0) ? r_mem[r_rdPtr] : '0;

    assign w_flush  = abort && (r_state != S_IDLE);
    assign w_launch = (r_state == S_IDLE) && start && (num_passes != '0);
    assign w_push   = r_tags[ROM_LATENCY-1];
    assign w_pop    = data_out_valid && data_out_ready;

    // Issue gate: reads in flight plus words already buffered must leave a free FIFO slot
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_tags[i]);
        end
        w_issue = (r_state == S_RUN) && !abort &&
                  (({1'b0, w_inflight} + {1'b0, r_count}) < OCC_W'(FIFO_DEPTH));
        w_lastIssue = w_issue && (r_addr == LAST_ADDR) &&
                      (r_pass == (r_numPasses - PASS_WIDTH'(1)));
        w_tagsNext    = r_tags << 1;
        w_tagsNext[0] = w_issue;
        w_countNext   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_drained     = (w_tagsNext == '0) && (w_countNext == '0);
    end

    // Next-state and done-pulse decode; done is registered so it lands on IDLE entry
    always_comb begin
        w_stateNext = r_state;
        w_doneNext  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (num_passes != '0)) begin
                    w_stateNext = S_RUN;
                end else if (start) begin
                    w_doneNext = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_stateNext = S_IDLE;
                end else if (w_lastIssue) begin
                    w_stateNext = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_stateNext = S_IDLE;
                end else if (w_drained) begin
                    w_stateNext = S_IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // State, address/pass counters and the in-flight tag shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pass      <= '0;
            r_numPasses <= '0;
            r_tags      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_done  <= w_doneNext;
            r_tags  <= w_flush ? '0 : w_tagsNext;
            if (w_launch) begin
                r_addr      <= '0;
                r_pass      <= '0;
                r_numPasses <= num_passes;
            end else if (w_flush) begin
                r_addr <= '0;
                r_pass <= '0;
            end else if (w_issue) begin
                if (r_addr == LAST_ADDR) begin
                    r_addr <= '0;
                    r_pass <= r_pass + PASS_WIDTH'(1);
                end else begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // FIFO occupancy and pointers; an abort empties it in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (w_flush) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
            r_count <= w_countNext;
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
        end
    end

    // FIFO storage captures the ROM word whose tag leaves the shift register
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= rom_q;
        end
    end

endmodule
